// File: rtl/vga_pixel_fifo_pkg.sv
// Shared VGA width parameters and small FIFO helpers.
package vga_pixel_fifo_pkg;

  localparam int unsigned VgaColorWidth = 4;
  localparam int unsigned VgaDataWidth  = 3 * VgaColorWidth;
  localparam int unsigned VgaFifoDepth  = 16;
  localparam int unsigned VgaAddrWidth  = 4;
  localparam int unsigned VgaLowMark    = 4;

  // Per-cycle FIFO activity, encoded as {pop, push}.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/vga_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// The read data is registered by the parent, so storage needs no reset.
module vga_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between a pixel producer and the VGA controller. Pops on pix_en,
// shows black and latches a sticky underflow when starved, flushes on frame_start.
module vga_pixel_fifo
  import vga_pixel_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VgaDataWidth,
  parameter int unsigned FIFO_DEPTH = VgaFifoDepth,
  parameter int unsigned ADDR_WIDTH = VgaAddrWidth,
  parameter int unsigned LOW_MARK   = VgaLowMark
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  pix_en,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_empty,
  output logic                  underflow
);

  localparam int unsigned LevelW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FullLevel = LevelW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LowLevel  = LevelW'(LOW_MARK);
  localparam logic [ADDR_WIDTH:0] LevelOne  = LevelW'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  underflow_q, underflow_d;

  logic                  push, pop, starve;
  logic [DATA_WIDTH-1:0] rd_data;

  vga_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push & rst_n),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  // Ready comes from the registered level only: a full FIFO never accepts,
  // even if it is popping in the same cycle.
  assign wr_ready     = (level_q != FullLevel);
  assign almost_empty = (level_q <= LowLevel);
  assign level        = level_q;
  assign Data_out     = data_out_q;
  assign underflow    = underflow_q;

  // Next-state for pointers, level, output word and underflow flag.
  always_comb begin
    push   = wr_valid && wr_ready && !frame_start;
    pop    = pix_en && (level_q != '0) && !frame_start;
    // Starved request: no write-to-read bypass, so a same-cycle push does not help.
    starve = pix_en && (level_q == '0) && !frame_start;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    data_out_d  = data_out_q;
    underflow_d = underflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_data;
    end
    if (starve) begin
      data_out_d  = '0;
      underflow_d = 1'b1;
    end

    case (fifo_op(push, pop))
      OpPush:  level_d = level_q + LevelOne;
      OpPop:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    // Frame flush overrides any same-cycle activity.
    if (frame_start) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      data_out_d  = '0;
      underflow_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      data_out_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      data_out_q  <= data_out_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
